// File: rtl/operand_ram.sv
// Multi-operand word store with independent write/read ports and a stream/clear sequencer.
// Latency: external read and sequencer stream words appear one cycle after issue.
// Backpressure: none; the sequencer takes over the read port (stream) or write port (clear).
//
// Ports: clk/rst_n; wr_en/wr_op/wr_addr/wr_data write port; rd_en/rd_op/rd_addr read
// request with rd_data/rd_valid response; seq_start/seq_clear/seq_op start a sequencer
// operation, seq_busy reports it; st_valid/st_last/st_data carry the streamed operand.
module operand_ram #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int NUM_OPS   = 4,
    parameter bit RDW_NEW   = 1'b0,
    parameter bit MSW_FIRST = 1'b0,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int OW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [OW-1:0]     wr_op,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [OW-1:0]     rd_op,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              seq_start,
    input  logic              seq_clear,
    input  logic [OW-1:0]     seq_op,
    output logic              seq_busy,
    output logic              st_valid,
    output logic              st_last,
    output logic [WORD_W-1:0] st_data
);

    // Flat index {op, addr}; with a single slot the op bit is dropped.
    localparam int IW    = AW + $clog2(NUM_OPS);
    localparam int DEPTH = NUM_OPS * NUM_WORDS;
    localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_CLEAR} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     cnt, cnt_nx;
    logic [OW-1:0]     op_q;

    logic              stream_rd;   // sequencer issues an internal read this cycle
    logic              clear_wr;    // sequencer writes zero this cycle
    logic              own_rd;      // sequencer owns the read port
    logic [AW-1:0]     seq_addr;

    logic              w_en;
    logic [IW-1:0]     w_idx;
    logic [WORD_W-1:0] w_dat;
    logic              ext_rd;
    logic [IW-1:0]     r_idx;
    logic [WORD_W-1:0] r_word;

    logic [WORD_W-1:0] mem [DEPTH];

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == S_IDLE && seq_start) begin
                op_q <= seq_op;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        stream_rd = 1'b0;
        clear_wr  = 1'b0;
        own_rd    = 1'b0;
        case (state)
            S_IDLE: begin
                if (seq_start) begin
                    state_nx = seq_clear ? S_CLEAR : S_STREAM;
                    cnt_nx   = '0;
                end
            end
            S_STREAM: begin
                stream_rd = 1'b1;
                own_rd    = 1'b1;
                if (cnt == LAST_WORD) state_nx = S_DRAIN;
                else                  cnt_nx   = cnt + AW'(1);
            end
            S_DRAIN: begin
                own_rd   = 1'b1;
                state_nx = S_IDLE;
            end
            S_CLEAR: begin
                clear_wr = 1'b1;
                if (cnt == LAST_WORD) state_nx = S_IDLE;
                else                  cnt_nx   = cnt + AW'(1);
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign seq_busy = (state != S_IDLE);

    // NUM_WORDS is a power of two, so NUM_WORDS-1-cnt is just ~cnt.
    assign seq_addr = MSW_FIRST ? ~cnt : cnt;

    // ---------------- port arbitration ----------------
    assign w_en   = clear_wr | wr_en;
    assign w_idx  = clear_wr ? IW'({op_q, cnt}) : IW'({wr_op, wr_addr});
    assign w_dat  = clear_wr ? '0 : wr_data;

    assign ext_rd = rd_en & ~own_rd;
    assign r_idx  = stream_rd ? IW'({op_q, seq_addr}) : IW'({rd_op, rd_addr});

    // Same-edge write to the read location is forwarded only when new data is wanted.
    assign r_word = (RDW_NEW && w_en && (w_idx == r_idx)) ? w_dat : mem[r_idx];

    // ---------------- storage (deliberately not reset) ----------------
    always_ff @(posedge clk) begin
        if (w_en) mem[w_idx] <= w_dat;
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            st_valid <= 1'b0;
            st_last  <= 1'b0;
            st_data  <= '0;
        end else begin
            rd_valid <= ext_rd;
            if (ext_rd) rd_data <= r_word;
            st_valid <= stream_rd;
            st_last  <= stream_rd && (cnt == LAST_WORD);
            if (stream_rd) st_data <= r_word;
        end
    end

endmodule

// File: tb/tb_operand_ram.sv
module tb_operand_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en, seq_start, seq_clear;
    logic [1:0]  wr_op, rd_op, seq_op;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    // dut0: RDW_NEW=0, MSW_FIRST=0; dut1: RDW_NEW=1, MSW_FIRST=1
    logic [31:0] rd_data0, rd_data1, st_data0, st_data1;
    logic        rd_valid0, rd_valid1, seq_busy0, seq_busy1;
    logic        st_valid0, st_valid1, st_last0, st_last1;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [4][8];

    always #5 clk = ~clk;

    operand_ram #(.RDW_NEW(1'b0), .MSW_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_op(rd_op), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0),
        .seq_start(seq_start), .seq_clear(seq_clear), .seq_op(seq_op),
        .seq_busy(seq_busy0), .st_valid(st_valid0), .st_last(st_last0), .st_data(st_data0)
    );

    operand_ram #(.RDW_NEW(1'b1), .MSW_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_op(rd_op), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1),
        .seq_start(seq_start), .seq_clear(seq_clear), .seq_op(seq_op),
        .seq_busy(seq_busy1), .st_valid(st_valid1), .st_last(st_last1), .st_data(st_data1)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t p256 [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 0; rd_en = 0; seq_start = 0; seq_clear = 0;
        wr_op = 0; wr_addr = 0; wr_data = 0; rd_op = 0; rd_addr = 0; seq_op = 0;
    endtask

    task automatic write_word(input int op, input int addr, input logic [31:0] d);
        wr_en = 1; wr_op = 2'(op); wr_addr = 3'(addr); wr_data = d;
        model[op][addr] = d;
        tick();
        wr_en = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_data0"}, rd_data0, 0);   chk({tag, "_rd_data1"}, rd_data1, 0);
        chk({tag, "_rd_valid0"}, rd_valid0, 0); chk({tag, "_rd_valid1"}, rd_valid1, 0);
        chk({tag, "_busy0"}, seq_busy0, 0);     chk({tag, "_busy1"}, seq_busy1, 0);
        chk({tag, "_st_valid0"}, st_valid0, 0); chk({tag, "_st_valid1"}, st_valid1, 0);
        chk({tag, "_st_last0"}, st_last0, 0);   chk({tag, "_st_last1"}, st_last1, 0);
        chk({tag, "_st_data0"}, st_data0, 0);   chk({tag, "_st_data1"}, st_data1, 0);
    endtask

    // Starts a stream in the current cycle (cycle 0) and returns in cycle 10,
    // the first non-busy cycle, so a following start is back-to-back.
    task automatic do_stream(input int op, input string tag);
        logic [31:0] exp [8];
        for (int k = 0; k < 8; k++) exp[k] = model[op][k];
        seq_start = 1; seq_clear = 0; seq_op = 2'(op);
        for (int c = 1; c <= 10; c++) begin
            tick();
            seq_start = 0;
            rd_en = (c == 4); rd_op = 2'(op); rd_addr = 0;
            chk($sformatf("%s_busy_c%0d", tag, c), {seq_busy1, seq_busy0}, (c <= 9) ? 2'b11 : 2'b00);
            chk($sformatf("%s_vld_c%0d", tag, c), {st_valid1, st_valid0}, (c >= 2 && c <= 9) ? 2'b11 : 2'b00);
            chk($sformatf("%s_last_c%0d", tag, c), {st_last1, st_last0}, (c == 9) ? 2'b11 : 2'b00);
            chk($sformatf("%s_rdv_c%0d", tag, c), {rd_valid1, rd_valid0}, 2'b00);
            if (c >= 2 && c <= 9) begin
                chk($sformatf("%s_lsw_c%0d", tag, c), st_data0, exp[c-2]);
                chk($sformatf("%s_msw_c%0d", tag, c), st_data1, exp[9-c]);
            end else if (c == 10) begin
                chk({tag, "_hold0"}, st_data0, exp[7]);
                chk({tag, "_hold1"}, st_data1, exp[0]);
            end
        end
        rd_en = 0;
    endtask

    initial begin
        logic [31:0] h0, h1, e0, e1;
        logic        same;

        p256[0] = '{2'd1, 3'd0, 32'hffffffff};
        p256[1] = '{2'd1, 3'd1, 32'hffffffff};
        p256[2] = '{2'd1, 3'd2, 32'hffffffff};
        p256[3] = '{2'd1, 3'd3, 32'h00000000};
        p256[4] = '{2'd1, 3'd4, 32'h00000000};
        p256[5] = '{2'd1, 3'd5, 32'h00000000};
        p256[6] = '{2'd1, 3'd6, 32'h00000001};
        p256[7] = '{2'd1, 3'd7, 32'hffffffff};

        idle_inputs();
        rst_n = 0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1;
        tick();

        // Fill every location with random data so the model is fully known.
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 8; a++)
                write_word(op, a, $urandom);

        // Random concurrent reads/writes against the model.
        h0 = 0; h1 = 0;
        for (int i = 0; i < 60; i++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_op = 2'($urandom_range(0, 3));
            wr_addr = 3'($urandom_range(0, 7)); wr_data = $urandom;
            rd_en = 1'($urandom_range(0, 1)); rd_op = 2'($urandom_range(0, 3));
            rd_addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin rd_op = wr_op; rd_addr = wr_addr; end
            same = wr_en && (wr_op == rd_op) && (wr_addr == rd_addr);
            e0 = model[rd_op][rd_addr];
            e1 = same ? wr_data : e0;
            if (wr_en) model[wr_op][wr_addr] = wr_data;
            if (rd_en) begin h0 = e0; h1 = e1; end
            tick();
            chk($sformatf("rnd_vld%0d", i), {rd_valid1, rd_valid0}, {rd_en, rd_en});
            chk($sformatf("rnd_rd0_%0d", i), rd_data0, h0);
            chk($sformatf("rnd_rd1_%0d", i), rd_data1, h1);
        end
        idle_inputs();

        // Test 1: P-256 prime into slot 1 from the table, then read back.
        for (int i = 0; i < 8; i++) write_word(p256[i].op, p256[i].addr, p256[i].data);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; rd_op = p256[i].op; rd_addr = p256[i].addr;
            tick();
            chk($sformatf("p256_rd0_%0d", i), rd_data0, p256[i].data);
            chk($sformatf("p256_rd1_%0d", i), rd_data1, p256[i].data);
        end
        rd_en = 1; rd_op = 1; rd_addr = 6;
        tick();
        rd_en = 0;
        chk("t1_rd_data", rd_data0, 32'h00000001);
        chk("t1_rd_valid", rd_valid0, 1);
        tick();
        chk("t1_rd_valid_idle", {rd_valid1, rd_valid0}, 2'b00);
        chk("t1_rd_hold", rd_data0, 32'h00000001);

        // Test 2: same-edge read/write of slot 0 addr 3.
        write_word(0, 3, 32'h0000aaaa);
        wr_en = 1; wr_op = 0; wr_addr = 3; wr_data = 32'h12345678;
        rd_en = 1; rd_op = 0; rd_addr = 3;
        model[0][3] = 32'h12345678;
        tick();
        idle_inputs();
        chk("t2_rdw_old", rd_data0, 32'h0000aaaa);
        chk("t2_rdw_new", rd_data1, 32'h12345678);
        rd_en = 1; rd_op = 0; rd_addr = 3;
        tick();
        rd_en = 0;
        chk("t2_after", rd_data0, 32'h12345678);

        // Test 3: stream slot 1 (LSW-first on dut0, MSW-first on dut1).
        do_stream(1, "t3");

        // Test 4: clear slot 1; external write in cycle 3 dropped, start in cycle 4 ignored.
        seq_start = 1; seq_clear = 1; seq_op = 1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            seq_start = 0; seq_clear = 0; wr_en = 0;
            if (c == 3) begin wr_en = 1; wr_op = 1; wr_addr = 0; wr_data = 32'hdeadbeef; end
            if (c == 4) begin seq_start = 1; seq_clear = 0; seq_op = 2; end
            chk($sformatf("t4_busy_c%0d", c), {seq_busy1, seq_busy0}, (c <= 8) ? 2'b11 : 2'b00);
            chk($sformatf("t4_vld_c%0d", c), {st_valid1, st_valid0}, 2'b00);
        end
        for (int a = 0; a < 8; a++) model[1][a] = 0;
        do_stream(1, "t4z");

        // Test 5: reset in cycle 5 of a stream.
        for (int i = 0; i < 8; i++) write_word(p256[i].op, p256[i].addr, p256[i].data);
        seq_start = 1; seq_clear = 0; seq_op = 1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            seq_start = 0;
        end
        chk("t5_pre_vld", {st_valid1, st_valid0}, 2'b11);
        #2;
        rst_n = 0;
        #1;
        check_all_zero("t5_async");
        tick();
        check_all_zero("t5_held");
        rst_n = 1;
        tick();
        chk("t5_idle", {seq_busy1, seq_busy0}, 2'b00);
        do_stream(1, "t5");

        // Test 6: back-to-back streams of slots 2 and 3, then a random slot.
        do_stream(2, "t6a");
        do_stream(3, "t6b");
        do_stream(int'($urandom_range(0, 3)), "rnds");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_ram.md
Name: operand_ram

Overview:
- Parametrised multi-operand word store for the P-256 datapath.
- Holds NUM_OPS operands, each NUM_WORDS words of WORD_W bits (default: 4 x 8 x 32 = four 256-bit operands).
- Provides an independent synchronous write port and read port, plus a built-in sequencer.
- The sequencer streams a whole operand out word by word with valid/last framing, or clears an operand to zero, without help from the controlling FSM.

Parameters:
- WORD_W, 32, bits per word.
- NUM_WORDS, 8, words per operand (power of two, >=2).
- NUM_OPS, 4, operand slots (power of two, >=1).
- RDW_NEW, 0, read-during-write to the same location: 0 returns old data, 1 returns new data.
- MSW_FIRST, 0, stream order: 0 streams word 0 first, 1 streams word NUM_WORDS-1 first.
- Derived: AW = clog2(NUM_WORDS); OW = max(1, clog2(NUM_OPS)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_op  in  OW  write operand slot
- wr_addr  in  AW  write word index
- wr_data  in  WORD_W  write data
- rd_en  in  1  read strobe
- rd_op  in  OW  read operand slot
- rd_addr  in  AW  read word index
- rd_data  out  WORD_W  read data
- rd_valid  out  1  rd_data is valid this cycle
- seq_start  in  1  start sequencer operation
- seq_clear  in  1  operation select, sampled with seq_start: 0 = stream, 1 = clear
- seq_op  in  OW  target operand slot, sampled with seq_start
- seq_busy  out  1  sequencer active
- st_valid  out  1  stream word valid
- st_last  out  1  final stream word
- st_data  out  WORD_W  stream word

Behaviour:
Storage and reset:
- Storage is NUM_OPS*NUM_WORDS words, flat index {op, addr}.
- Storage is not reset; contents are unchanged by rst_n.
- rst_n low: rd_data=0, rd_valid=0, seq_busy=0, st_valid=0, st_last=0, st_data=0, sequencer returns to IDLE. This applies mid-operation; a partial clear leaves already-zeroed words zero.

External ports:
- Write commits at the clock edge where wr_en=1.
- Read has one-cycle latency: rd_en sampled at edge T; rd_data and rd_valid update at edge T and hold for the following cycle. rd_valid=0 in any cycle without an accepted read.
- rd_data holds its last value when no read occurs.
- Read-during-write to the same {op, addr} at the same edge: RDW_NEW=0 returns the pre-write word, RDW_NEW=1 returns wr_data.
- Different addresses never interact.

Sequencer FSM (IDLE, STREAM, DRAIN, CLEAR):
- IDLE: seq_start=1 captures seq_op and seq_clear, resets the word counter, and moves to STREAM or CLEAR. seq_busy=1 from the next cycle.
- seq_start while seq_busy=1 is ignored.
- STREAM: issues one internal read per cycle for NUM_WORDS cycles, word order set by MSW_FIRST, then moves to DRAIN.
- DRAIN: one cycle for the final word, then IDLE.
- Stream timing, with start in cycle 0: st_valid=1 in cycles 2..NUM_WORDS+1, st_last=1 only in cycle NUM_WORDS+1, seq_busy=1 in cycles 1..NUM_WORDS+1. st_data is held when st_valid=0.
- CLEAR: writes zero to word k of the captured slot in cycle k+1, k=0..NUM_WORDS-1, then returns to IDLE. seq_busy=1 in cycles 1..NUM_WORDS. No stream outputs.
- Back-to-back: seq_start may be asserted in the first cycle seq_busy=0.

Arbitration:
- While seq_busy=1 in STREAM/DRAIN, the sequencer owns the read port: rd_en is ignored and rd_valid=0.
- While in CLEAR, the sequencer owns the write port: wr_en is dropped with no effect.
- The external write during STREAM is allowed. A stream word reflects memory contents at the edge its internal read is issued, using RDW_NEW semantics.

Width rule: no arithmetic on data; word index wrap is impossible because the counter stops at NUM_WORDS-1.

Test Plan:
1. Write slot 1 words 0..7 with P-256 prime, LSW first (ffffffff, ffffffff, ffffffff, 00000000, 00000000, 00000000, 00000001, ffffffff); read slot 1 addr 6 -> rd_data=00000001 and rd_valid=1 exactly one cycle after rd_en, rd_valid=0 the next idle cycle.
2. Same-edge write 12345678 and read of slot 0 addr 3 (prior value 0000aaaa) -> rd_data=0000aaaa with RDW_NEW=0; 12345678 with RDW_NEW=1.
3. Stream slot 1 (contents from test 1), MSW_FIRST=0, start in cycle 0 -> st_valid cycles 2..9, st_data ffffffff, ffffffff, ffffffff, 0, 0, 0, 00000001, ffffffff, st_last only in cycle 9, seq_busy cycles 1..9; rd_en pulsed in cycle 4 produces no rd_valid. Repeat with MSW_FIRST=1 -> reverse order.
4. Clear slot 1 with wr_en to slot 1 addr 0 in cycle 3, then stream slot 1 -> all eight words 00000000; seq_start in cycle 4 of the clear is ignored.
5. Assert rst_n low in cycle 5 of a stream -> all outputs 0 asynchronously, FSM IDLE; after release, a new stream of slot 1 completes with correct framing.
6. Back-to-back streams of slots 2 and 3 with seq_start in the first non-busy cycle -> two clean 8-word frames, each with exactly one st_last.
